// File: rtl/data_ram_arbiter.sv
// Two-master arbiter/sequencer for the single-port data RAM: ack 1+RAM_LATENCY cycles after grant (1 if out of range).
// Backpressure: the master is stalled combinationally until its ack; requests are only sampled in IDLE.
module data_ram_arbiter #(
  parameter int RAM_AW      = 5,
  parameter int RAM_LATENCY = 1,
  parameter bit FIXED_PRI   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_din,
  output logic        m0_ack,
  output logic [31:0] m0_dout,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_din,
  output logic        m1_ack,
  output logic [31:0] m1_dout,
  output logic        m1_stall,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  localparam int CW = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic id;
    logic we;
  } txn_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  txn_t        txn_q, txn_d;

  logic        ram_cs_d, ram_we_d;
  logic [31:0] ram_addr_d, ram_din_d;
  logic        m0_ack_d, m1_ack_d;
  logic [31:0] m0_dout_d, m1_dout_d;

  logic        gnt, gnt_we, gnt_in_range;
  logic [31:0] gnt_addr, gnt_din, resp_dat;

  assign m0_stall = m0_req & ~m0_ack;
  assign m1_stall = m1_req & ~m1_ack;

  // On a tie, round-robin hands the grant to whoever did not get it last.
  always_comb begin
    if (m0_req && m1_req) gnt = FIXED_PRI ? 1'b0 : ~last_grant_q;
    else                  gnt = m1_req;
    gnt_we       = gnt ? m1_we   : m0_we;
    gnt_addr     = gnt ? m1_addr : m0_addr;
    gnt_din      = gnt ? m1_din  : m0_din;
    gnt_in_range = (gnt_addr[31:RAM_AW] == '0);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    txn_d        = txn_q;
    ram_cs_d     = ram_cs;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr;
    ram_din_d    = ram_din;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_dout_d    = m0_dout;
    m1_dout_d    = m1_dout;
    resp_dat     = txn_q.we ? 32'h0 : ram_dout;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          last_grant_d = gnt;
          txn_d        = '{id: gnt, we: gnt_we};
          if (gnt_in_range) begin
            state_d    = BUSY;
            ram_cs_d   = 1'b1;
            ram_we_d   = gnt_we;
            ram_addr_d = gnt_addr;
            ram_din_d  = gnt_din;
            cnt_d      = CW'(RAM_LATENCY);
          end else begin
            // Out-of-range: never touch the RAM, answer with zero data.
            state_d = RESP;
            if (gnt) begin
              m1_ack_d  = 1'b1;
              m1_dout_d = 32'h0;
            end else begin
              m0_ack_d  = 1'b1;
              m0_dout_d = 32'h0;
            end
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = RESP;
          ram_cs_d = 1'b0;
          if (txn_q.id) begin
            m1_ack_d  = 1'b1;
            m1_dout_d = resp_dat;
          end else begin
            m0_ack_d  = 1'b1;
            m0_dout_d = resp_dat;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      txn_q        <= '0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= 32'h0;
      ram_din      <= 32'h0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_dout      <= 32'h0;
      m1_dout      <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      txn_q        <= txn_d;
      ram_cs       <= ram_cs_d;
      ram_we       <= ram_we_d;
      ram_addr     <= ram_addr_d;
      ram_din      <= ram_din_d;
      m0_ack       <= m0_ack_d;
      m1_ack       <= m1_ack_d;
      m0_dout      <= m0_dout_d;
      m1_dout      <= m1_dout_d;
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Three arbiter configurations (round-robin, fixed priority, 2-cycle RAM) driven by one shared stimulus,
// each with its own RAM model.
module tb_data_ram_arbiter;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [31:0]   m0_addr, m0_din, m1_addr, m1_din;
  logic [NI-1:0] m0_ack, m1_ack, m0_stall, m1_stall, ram_cs, ram_we;
  logic [31:0]   m0_dout  [NI];
  logic [31:0]   m1_dout  [NI];
  logic [31:0]   ram_addr [NI];
  logic [31:0]   ram_din  [NI];
  logic [31:0]   ram_dout [NI];
  logic [31:0]   mem      [NI][32];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_ram_arbiter #(
      .RAM_AW(5), .RAM_LATENCY(g == 2 ? 2 : 1), .FIXED_PRI(g == 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
      .m0_ack(m0_ack[g]), .m0_dout(m0_dout[g]), .m0_stall(m0_stall[g]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
      .m1_ack(m1_ack[g]), .m1_dout(m1_dout[g]), .m1_stall(m1_stall[g]),
      .ram_cs(ram_cs[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]),
      .ram_din(ram_din[g]), .ram_dout(ram_dout[g])
    );
    assign ram_dout[g] = mem[g][ram_addr[g][4:0]];
  end

  always @(posedge clk)
    for (int i = 0; i < NI; i++)
      if (ram_cs[i] && ram_we[i]) mem[i][ram_addr[i][4:0]] = ram_din[i];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] din);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_din = din;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_din = din;
    end
  endtask

  function automatic logic ack_of(input int idx, input logic m);
    return m ? m1_ack[idx] : m0_ack[idx];
  endfunction

  function automatic logic [31:0] dout_of(input int idx, input logic m);
    return m ? m1_dout[idx] : m0_dout[idx];
  endfunction

  task automatic reset_pulse();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  // One access: req held until ack (bounded), latency counted in cycles from the sampling edge.
  task automatic do_access(input int idx, input logic m, input logic we, input logic [31:0] addr,
                           input logic [31:0] din, output int lat, output logic [31:0] dout,
                           output int ncs, output int nwe, output logic oth);
    lat = 0; ncs = 0; nwe = 0; oth = 1'b0; dout = 32'h0;
    @(negedge clk);
    drive(m, 1'b1, we, addr, din);
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      ncs += int'(ram_cs[idx]);
      nwe += int'(ram_we[idx]);
      if (ack_of(idx, m)) begin
        lat  = t;
        dout = dout_of(idx, m);
        oth  = ack_of(idx, !m);
        break;
      end
    end
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    int          exp_lat;
    int          exp_cs;
    int          exp_we;
  } vec_t;
  vec_t vecs [10];

  // Transaction-level reference for the round-robin instance during random traffic.
  logic        rq [2];
  logic        rwe [2];
  logic [31:0] raddr [2];
  logic [31:0] rdin [2];
  logic [31:0] mmem [32];
  logic [31:0] exp_dout [2];
  logic [31:0] pend_data;
  logic        lastg, exp_a, inr;
  int          ack_at, idle_at, win;

  initial begin
    int lat, ncs, nwe;
    logic [31:0] dv;
    logic oth;

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 32; a++) mem[i][a] = 32'hA5A5_0000 | 32'(a);
      mem[i][3] = 32'hDEADBEEF;
    end

    vecs[0] = '{1'b0, 1'b0, 32'd3,         32'h0,         32'hDEADBEEF, 2, 1, 0};
    vecs[1] = '{1'b0, 1'b0, 32'h20,        32'h0,         32'h0,        1, 0, 0};
    vecs[2] = '{1'b1, 1'b1, 32'd7,         32'h12345678,  32'h0,        2, 1, 1};
    vecs[3] = '{1'b1, 1'b0, 32'd7,         32'h0,         32'h12345678, 2, 1, 0};
    vecs[4] = '{1'b0, 1'b1, 32'h40,        32'hFFFFFFFF,  32'h0,        1, 0, 0};
    vecs[5] = '{1'b0, 1'b0, 32'h40,        32'h0,         32'h0,        1, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h0,        1, 0, 0};
    vecs[7] = '{1'b0, 1'b1, 32'h1F,        32'hCAFEF00D,  32'h0,        2, 1, 1};
    vecs[8] = '{1'b1, 1'b0, 32'h1F,        32'h0,         32'hCAFEF00D, 2, 1, 0};
    vecs[9] = '{1'b0, 1'b0, 32'd0,         32'h0,         32'hA5A5_0000, 2, 1, 0};

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d_ram_cs", i),   ram_cs[i],   1'b0);
      check($sformatf("rst%0d_ram_we", i),   ram_we[i],   1'b0);
      check($sformatf("rst%0d_ram_addr", i), ram_addr[i], 32'h0);
      check($sformatf("rst%0d_ram_din", i),  ram_din[i],  32'h0);
      check($sformatf("rst%0d_m0_ack", i),   m0_ack[i],   1'b0);
      check($sformatf("rst%0d_m1_ack", i),   m1_ack[i],   1'b0);
      check($sformatf("rst%0d_m0_dout", i),  m0_dout[i],  32'h0);
      check($sformatf("rst%0d_m1_dout", i),  m1_dout[i],  32'h0);
      check($sformatf("rst%0d_m0_stall", i), m0_stall[i], 1'b0);
      check($sformatf("rst%0d_m1_stall", i), m1_stall[i], 1'b0);
    end
    rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      do_access(0, vecs[v].m, vecs[v].we, vecs[v].addr, vecs[v].din, lat, dv, ncs, nwe, oth);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_dout", v), dv, vecs[v].exp_dout);
      check($sformatf("vec%0d_cs_cycles", v), ncs, vecs[v].exp_cs);
      check($sformatf("vec%0d_we_cycles", v), nwe, vecs[v].exp_we);
      check($sformatf("vec%0d_other_ack", v), oth, 1'b0);
    end

    // In-range read, cycle by cycle.
    reset_pulse();
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'd3, 32'h0); #1;
    check("t1_stall_at_T", m0_stall[0], 1'b1);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      check($sformatf("t1_cs_%0d", t), ram_cs[0], t == 1);
      check($sformatf("t1_stall_%0d", t), m0_stall[0], t == 1);
      check($sformatf("t1_ack_%0d", t), m0_ack[0], t == 2);
    end
    check("t1_dout", m0_dout[0], 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Both masters hold req; m0 drops after its 4th ack, m1 after its next ack on the fixed-priority unit.
    reset_pulse();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd3, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd7, 32'h0);
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      check($sformatf("rr_m0_ack_%0d", t), m0_ack[0], t inside {2, 8});
      check($sformatf("rr_m1_ack_%0d", t), m1_ack[0], t inside {5, 11, 14});
      check($sformatf("fp_m0_ack_%0d", t), m0_ack[1], t inside {2, 5, 8, 11});
      check($sformatf("fp_m1_ack_%0d", t), m1_ack[1], t == 14);
      check($sformatf("fp_m1_stall_%0d", t), m1_stall[1], t < 14);
      if (t == 11) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (t == 14) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Reset during the second BUSY cycle of a 2-cycle RAM read.
    reset_pulse();
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'd3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t6_cs_before_rst", ram_cs[2], 1'b1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b1;
    check("t6_ram_cs", ram_cs[2], 1'b0);
    check("t6_ram_we", ram_we[2], 1'b0);
    check("t6_ram_addr", ram_addr[2], 32'h0);
    check("t6_ram_din", ram_din[2], 32'h0);
    check("t6_m0_ack", m0_ack[2], 1'b0);
    check("t6_m0_dout", m0_dout[2], 32'h0);
    check("t6_m1_dout", m1_dout[2], 32'h0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check($sformatf("t6_no_ack_%0d", t), m0_ack[2], 1'b0);
    end
    do_access(2, 1'b0, 1'b0, 32'd3, 32'h0, lat, dv, ncs, nwe, oth);
    check("t6_reissue_latency", lat, 3);
    check("t6_reissue_dout", dv, 32'hDEADBEEF);
    check("t6_reissue_cs_cycles", ncs, 2);

    // Random traffic on the round-robin unit against the transaction model.
    for (int m = 0; m < 2; m++) begin
      rq[m] = 1'b0; rwe[m] = 1'b0; raddr[m] = 32'h0; rdin[m] = 32'h0; exp_dout[m] = 32'h0;
    end
    reset_pulse();
    for (int a = 0; a < 32; a++) mmem[a] = mem[0][a];
    lastg = 1'b1; ack_at = -1; idle_at = 0; win = 0; pend_data = 32'h0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        exp_a = (ack_at == k) && (win == m);
        check($sformatf("rnd_ack%0d_c%0d", m, k), ack_of(0, m[0]), exp_a);
        if (exp_a) exp_dout[m] = pend_data;
        check($sformatf("rnd_dout%0d_c%0d", m, k), dout_of(0, m[0]), exp_dout[m]);
        check($sformatf("rnd_stall%0d_c%0d", m, k), m ? m1_stall[0] : m0_stall[0], rq[m] & ~exp_a);
        if (exp_a) rq[m] = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        if (!rq[m] && $urandom_range(0, 2) == 0) begin
          rq[m]  = 1'b1;
          rwe[m] = $urandom_range(0, 1) == 1;
          rdin[m] = $urandom;
          case ($urandom_range(0, 7))
            0:       raddr[m] = $urandom | 32'h0000_0100;
            1:       raddr[m] = 32'h20;
            default: raddr[m] = 32'($urandom_range(0, 31));
          endcase
        end
        drive(m[0], rq[m], rwe[m], raddr[m], rdin[m]);
      end
      if (k >= idle_at && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) win = lastg ? 0 : 1;
        else                win = rq[1] ? 1 : 0;
        lastg = (win == 1);
        inr = raddr[win] < 32'd32;
        pend_data = (!inr || rwe[win]) ? 32'h0 : mmem[raddr[win][4:0]];
        if (inr && rwe[win]) mmem[raddr[win][4:0]] = rdin[win];
        ack_at  = k + (inr ? 2 : 1);
        idle_at = ack_at + 1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
Two-master arbiter and sequencer in front of the single-port data RAM. Master 0 is the CPU MEM stage and master 1 is the debug/DMA port. The block serialises their requests, drives the RAM's chip-select, write-enable, address and data, and waits out the RAM read latency. It returns read data with a one-cycle ack and generates per-master stall so the pipeline freezes until its access completes.

Parameters:
RAM_AW, 5, RAM word-address width; addresses with addr[31:RAM_AW] != 0 are out of range.
RAM_LATENCY, 1, cycles (>=1) from the first ram_cs cycle until ram_dout is valid.
FIXED_PRI, 0, 0 = round-robin arbitration; 1 = master 0 always wins.

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-low
m0_req  in  1  master 0 request, held until m0_ack
m0_we  in  1  master 0 write (1) / read (0)
m0_addr  in  32  master 0 word address
m0_din  in  32  master 0 write data
m0_ack  out  1  one-cycle completion pulse
m0_dout  out  32  read data, valid while m0_ack=1
m0_stall  out  1  m0_req & ~m0_ack (combinational)
m1_req, m1_we, m1_addr, m1_din, m1_ack, m1_dout, m1_stall  same as m0_*, for master 1
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_addr  out  32  RAM address
ram_din  out  32  RAM write data
ram_dout  in  32  RAM read data

Behaviour:
- Reset (rst=0 at posedge): go to IDLE. ram_cs, ram_we, m0_ack and m1_ack become 0. ram_addr, ram_din, m0_dout and m1_dout become 0. last_grant becomes 1, so master 0 wins the first tie.
- Reset mid-operation: the in-flight transaction is abandoned with no ack. A write pulse already issued is not undone. The stall outputs follow req while acks are 0.
- All outputs except the stall outputs are registered.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req: pick the winner. Latch the winner id, we, addr and din.
  - In-range address: go to BUSY. Set ram_cs=1, ram_addr=addr, ram_din=din, ram_we=we. Load cnt=RAM_LATENCY.
  - Out-of-range address: go directly to RESP. ram_cs stays 0, a write is dropped, and read data is 0.
- Arbitration when both masters request in IDLE:
  - FIXED_PRI=1: master 0 wins.
  - FIXED_PRI=0: the master not in last_grant wins.
  - last_grant updates on every grant.
  - A single requester always wins.
- BUSY:
  - ram_cs, ram_addr and ram_din are held.
  - ram_we is high only in the first BUSY cycle; it clears on the next edge.
  - cnt decrements each cycle.
  - When cnt==1, go to RESP. On that same edge, ram_cs=0 and the winner's mN_dout is captured from ram_dout for a read, or set to 0 for a write.
- RESP:
  - The winner's mN_ack=1 for exactly one cycle and mN_dout is valid. The other master's ack stays 0.
  - Next state is always IDLE.
  - After RESP, mN_dout holds its value until overwritten.
- Latency from req sampled at edge T:
  - In-range access: ack at T+1+RAM_LATENCY, i.e. T+2 for the default.
  - Out-of-range access: ack at T+1.
- Back-to-back: a master keeping req high after its ack is re-sampled in the following IDLE cycle. Minimum spacing is 3 cycles per access at RAM_LATENCY=1.
- Requests arriving in BUSY or RESP are not sampled. Requests must stay stable until ack; a req dropped before ack is protocol misuse and the access still completes.
- Address compare is on the full 32 bits: out of range iff addr[31:RAM_AW] != 0.

Test Plan:
1. Read, in range:
   - Stimulus: RAM[3]=0xDEADBEEF, RAM_LATENCY=1; m0 read addr 3, req sampled at T.
   - Response: ram_cs=1 at T+1 only; m0_ack=1 at T+2 with m0_dout=0xDEADBEEF; m0_stall=1 during T..T+1 and 0 at T+2.
2. Write then read back:
   - Stimulus: m1 write addr 7, din 0x12345678; then m1 read addr 7.
   - Response: ram_we high exactly one cycle with ram_addr=7; second ack returns m1_dout=0x12345678; first ack returns m1_dout=0.
3. Round-robin contention:
   - Stimulus: FIXED_PRI=0; m0 and m1 both hold req for 4 transactions.
   - Response: grant order m0, m1, m0, m1; acks at T+2, T+5, T+8, T+11.
4. Fixed priority:
   - Stimulus: FIXED_PRI=1; both hold req.
   - Response: m0 acked every 3 cycles; m1_ack stays 0 and m1_stall stays 1 until m0 drops req, then m1 is acked 3 cycles later.
5. Out of range:
   - Stimulus: m0 write addr 0x40, din 0xFFFFFFFF; then m0 read addr 0x40.
   - Response: ram_cs never asserted; each ack at T+1 with m0_dout=0; RAM[0] unchanged.
6. Reset and latency variant:
   - Stimulus: RAM_LATENCY=2; rst=0 pulsed during the second BUSY cycle of an m0 read.
   - Response: after that edge, all registered outputs are 0, state is IDLE and no m0_ack occurs; a re-issued read acks at T+3.
